// File: rtl/solomon_video_timing_if.sv
// Raster interface between the Solomon's Key timing source (master) and its consumers (slave).
// HOFS/VOFS exist only when SOLOMON_VTG_ADJ_EN is defined.
interface solomon_video_timing_if;
    // No handshake: PCE qualifies the cycle on which PHi/PVi and the decoded
    // outputs hold a new pixel. Consumers sample them on PCE cycles, never stall.
    logic       PCE;
    logic       PCEx2;
    logic [8:0] PHi;
    logic [8:0] PVi;
    logic       HSYNC;
    logic       VSYNC;
    logic       HBLANK;
    logic       VBLANK;
    logic       FSTART;
`ifdef SOLOMON_VTG_ADJ_EN
    logic [3:0] HOFS;
    logic [2:0] VOFS;

    modport master (
        output PCE, PCEx2, PHi, PVi, HSYNC, VSYNC, HBLANK, VBLANK, FSTART,
        input  HOFS, VOFS
    );
    modport slave (
        input  PCE, PCEx2, PHi, PVi, HSYNC, VSYNC, HBLANK, VBLANK, FSTART,
        output HOFS, VOFS
    );
`else
    modport master (
        output PCE, PCEx2, PHi, PVi, HSYNC, VSYNC, HBLANK, VBLANK, FSTART
    );
    modport slave (
        input  PCE, PCEx2, PHi, PVi, HSYNC, VSYNC, HBLANK, VBLANK, FSTART
    );
`endif
endinterface

// File: rtl/solomon_video_timing.sv
// Solomon's Key master video timing: pixel enables, PHi/PVi raster counters, sync/blank, frame strobe.
// Optional SOLOMON_VTG_ADJ_EN adds HOFS/VOFS sync shifts latched once per frame.
module solomon_video_timing #(
    parameter int H_TOTAL   = 384,
    parameter int H_VISIBLE = 256,
    parameter int HS_START  = 304,
    parameter int HS_END    = 336,
    parameter int V_TOTAL   = 264,
    parameter int V_VISIBLE = 224,
    parameter int VS_START  = 240,
    parameter int VS_END    = 243
) (
    input logic                    VCLKx4,
    input logic                    RSTn,
    solomon_video_timing_if.master vt
);
    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
    localparam logic [8:0] H_VIS  = 9'(H_VISIBLE);
    localparam logic [8:0] V_VIS  = 9'(V_VISIBLE);
    localparam logic [8:0] HS_LO  = 9'(HS_START);
    localparam logic [8:0] HS_HI  = 9'(HS_END);
    localparam logic [8:0] VS_LO  = 9'(VS_START);
    localparam logic [8:0] VS_HI  = 9'(VS_END);

    logic [1:0] div;
    logic       pce;
    logic       pcex2;
    logic       fstart;
    logic [8:0] phi;
    logic [8:0] pvi;
    logic [8:0] phi_n;
    logic [8:0] pvi_n;
    logic       hsync;
    logic       vsync;
    logic       hblank;
    logic       vblank;
    logic       line_wrap;
    logic       frame_wrap;
    logic [8:0] h_ofs;
    logic [8:0] v_ofs;
    logic [8:0] hs_lo;
    logic [8:0] hs_hi;
    logic [8:0] vs_lo;
    logic [8:0] vs_hi;

    always_comb begin
        line_wrap  = pce && (phi == H_LAST);
        frame_wrap = line_wrap && (pvi == V_LAST);
        phi_n      = phi;
        pvi_n      = pvi;
        if (line_wrap) begin
            phi_n = '0;
            pvi_n = (pvi == V_LAST) ? '0 : pvi + 9'd1;
        end else if (pce) begin
            phi_n = phi + 9'd1;
        end
    end

`ifdef SOLOMON_VTG_ADJ_EN
    logic [3:0] hofs_q;
    logic [2:0] vofs_q;

    always_ff @(posedge VCLKx4 or negedge RSTn) begin
        if (!RSTn) begin
            hofs_q <= '0;
            vofs_q <= '0;
        end else if (frame_wrap) begin
            hofs_q <= vt.HOFS;
            vofs_q <= vt.VOFS;
        end
    end

    // On the wrap edge the incoming offsets already govern line 0 of the new frame.
    always_comb begin
        if (frame_wrap) begin
            h_ofs = {{5{vt.HOFS[3]}}, vt.HOFS};
            v_ofs = {{6{vt.VOFS[2]}}, vt.VOFS};
        end else begin
            h_ofs = {{5{hofs_q[3]}}, hofs_q};
            v_ofs = {{6{vofs_q[2]}}, vofs_q};
        end
    end
`else
    assign h_ofs = '0;
    assign v_ofs = '0;
`endif

    // 9-bit wrap-around add makes a negative offset a plain subtraction.
    assign hs_lo = HS_LO + h_ofs;
    assign hs_hi = HS_HI + h_ofs;
    assign vs_lo = VS_LO + v_ofs;
    assign vs_hi = VS_HI + v_ofs;

    always_ff @(posedge VCLKx4 or negedge RSTn) begin
        if (!RSTn) begin
            div    <= '0;
            pce    <= 1'b0;
            pcex2  <= 1'b0;
            fstart <= 1'b0;
            phi    <= '0;
            pvi    <= '0;
            hsync  <= 1'b1;
            vsync  <= 1'b1;
            hblank <= 1'b0;
            vblank <= 1'b0;
        end else begin
            div    <= div + 2'd1;
            pce    <= (div == 2'd3);
            pcex2  <= div[0];
            fstart <= frame_wrap;
            phi    <= phi_n;
            pvi    <= pvi_n;
            // Decode from the next-state counters so outputs move with PHi/PVi.
            if (pce) begin
                hsync  <= !((phi_n >= hs_lo) && (phi_n < hs_hi));
                vsync  <= !((pvi_n >= vs_lo) && (pvi_n < vs_hi));
                hblank <= (phi_n >= H_VIS);
                vblank <= (pvi_n >= V_VIS);
            end
        end
    end

    assign vt.PCE    = pce;
    assign vt.PCEx2  = pcex2;
    assign vt.PHi    = phi;
    assign vt.PVi    = pvi;
    assign vt.HSYNC  = hsync;
    assign vt.VSYNC  = vsync;
    assign vt.HBLANK = hblank;
    assign vt.VBLANK = vblank;
    assign vt.FSTART = fstart;
endmodule
